// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler input port.
//   NUM_BUTTONS : number of board pushbuttons
//   DEBOUNCE_W  : width of each per-button debounce counter
//   buttons_t   : button vector type shared with the CPU pushbuttons port
package nibbler_pkg;
   localparam int NUM_BUTTONS = 4;
   localparam int DEBOUNCE_W  = 16;

   typedef logic [NUM_BUTTONS-1:0] buttons_t;
endpackage

// File: rtl/nibbler_debounce.sv
// One pushbutton: two-flop synchronizer, saturating debounce counter,
// debounced level and a one-cycle press pulse.
//   clk, reset : clock and synchronous active-high reset
//   raw        : asynchronous button level, 1 = pressed
//   press      : registered pulse, high for one cycle when the debounced
//                level goes 0 -> 1
module nibbler_debounce
   import nibbler_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam logic [DEBOUNCE_W-1:0] LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

   logic                  sync1;
   logic                  sync2;
   logic                  stable;
   logic [DEBOUNCE_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            // Level has differed for DEBOUNCE_CYCLES consecutive cycles.
            stable <= sync2;
            cnt    <= '0;
            press  <= sync2;
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/nibbler_input_port.sv
// Nibbler CPU input port: debounces four pushbuttons and latches press
// flags until the CPU reads them.
//   clk, reset   : clock and synchronous active-high reset
//   rawButtons   : asynchronous board buttons, 1 = pressed
//   readStrobe   : one-cycle pulse when the CPU consumes the button value
//   pushbuttons  : latched press flags for the CPU
//   pressPending : OR of pushbuttons
//   overrun      : per-button flag, a press arrived while still unread
module nibbler_input_port
   import nibbler_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  buttons_t rawButtons,
   input  logic     readStrobe,
   output buttons_t pushbuttons,
   output logic     pressPending,
   output buttons_t overrun
);

   buttons_t press;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      nibbler_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .reset(reset),
         .raw  (rawButtons[i]),
         .press(press[i])
      );
   end

   // A read clears the flags, but a coincident press always wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         pushbuttons <= '0;
         overrun     <= '0;
      end else begin
         pushbuttons <= (readStrobe ? '0 : pushbuttons) | press;
         overrun     <= (readStrobe ? '0 : overrun) | (press & pushbuttons);
      end
   end

   assign pressPending = |pushbuttons;

endmodule
